// File: rtl/fetch_pkg.sv
// +--------------------------------------------------------------------+
// | fetch_pkg : shared types and constants for the instruction fetcher |
// | Revision  : 1.0                                                    |
// +--------------------------------------------------------------------+
`default_nettype none

package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    FAULT = 3'd4
  } fetch_state_e;

  typedef enum logic [1:0] {
    FC_NONE     = 2'd0,
    FC_MISALIGN = 2'd1,
    FC_BUSERR   = 2'd2,
    FC_TIMEOUT  = 2'd3
  } fault_cause_e;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_timer.sv
// +--------------------------------------------------------------------+
// | fetch_timer : saturating transaction timer with clear and expire   |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
`default_nettype none

module fetch_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != CNT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Expiry fires on the last permitted cycle so the FSM can leave on that edge.
  generate
    if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
      assign expire_o = 1'b0;
    end else begin : g_timeout
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
      assign expire_o = en_i && (count_q == CNT_LAST);
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// +--------------------------------------------------------------------+
// | instr_fetch : single-word instruction fetch with fault reporting   |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
`default_nettype none

module instr_fetch #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] NOP_INSTR      = fetch_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_start_i,
  input  logic [31:0] pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        imem_err_i,
  output logic [31:0] ir_o,
  output logic [31:0] ir_pc_o,
  output logic [31:0] pc_next_o,
  output logic        pc_ld_o,
  output logic        fetch_done_o,
  output logic        fetch_fault_o,
  output logic [1:0]  fault_cause_o,
  output logic        busy_o
);

  import fetch_pkg::*;

  fetch_state_e state_q, state_d;
  fault_cause_e cause_q, cause_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  ir_q, ir_d;
  logic [31:0]  ir_pc_q, ir_pc_d;

  logic timer_clr;
  logic timer_en;
  logic timer_expire;
  logic resp_valid;

  assign timer_en   = (state_q == REQ) || (state_q == WAIT);
  // A zero-latency response in REQ is treated exactly like one seen in WAIT.
  assign resp_valid = imem_rvalid_i &&
                      (((state_q == REQ) && imem_gnt_i) || (state_q == WAIT));

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    addr_d    = addr_q;
    ir_d      = ir_q;
    ir_pc_d   = ir_pc_q;
    timer_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (fetch_start_i) begin
          cause_d = FC_NONE;
          if (!is_word_aligned(pc_i)) begin
            cause_d = FC_MISALIGN;
            state_d = FAULT;
          end else begin
            addr_d    = pc_i;
            timer_clr = 1'b1;
            state_d   = REQ;
          end
        end
      end
      REQ, WAIT: begin
        if (resp_valid) begin
          if (imem_err_i) begin
            cause_d = FC_BUSERR;
            state_d = FAULT;
          end else begin
            ir_d    = imem_rdata_i;
            ir_pc_d = addr_q;
            state_d = DONE;
          end
        end else if (timer_expire) begin
          cause_d = FC_TIMEOUT;
          state_d = FAULT;
        end else if ((state_q == REQ) && imem_gnt_i) begin
          state_d = WAIT;
        end
      end
      DONE:    state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cause_q <= FC_NONE;
      addr_q  <= 32'h0;
      ir_q    <= NOP_INSTR;
      ir_pc_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      ir_pc_q <= ir_pc_d;
    end
  end

  fetch_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (timer_clr),
    .en_i     (timer_en),
    .expire_o (timer_expire)
  );

  // Strobes decode straight from state so a reset drops them without a clock.
  assign imem_req_o    = (state_q == REQ);
  assign imem_addr_o   = addr_q;
  assign ir_o          = ir_q;
  assign ir_pc_o       = ir_pc_q;
  assign pc_next_o     = ir_pc_q + 32'd4;
  assign pc_ld_o       = (state_q == DONE);
  assign fetch_done_o  = (state_q == DONE);
  assign fetch_fault_o = (state_q == FAULT);
  assign fault_cause_o = cause_q;
  assign busy_o        = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// +--------------------------------------------------------------------+
// | tb_instr_fetch : self-checking bench for instr_fetch               |
// | Revision       : 1.0                                               |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_instr_fetch;

  localparam int          TO_MAIN = 8;
  localparam int          TO_SHORT = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, gnt, rvalid, err;
  logic [31:0] pc, rdata;
  logic        req, pc_ld, done, fault, busy;
  logic [31:0] addr, ir, ir_pc, pc_next;
  logic [1:0]  cause;

  logic        t_start;
  logic [31:0] t_pc;
  logic        t_req, t_pc_ld, t_done, t_fault, t_busy;
  logic [31:0] t_addr, t_ir, t_ir_pc, t_pc_next;
  logic [1:0]  t_cause;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] m_ir    = NOP;
  logic [31:0] m_ir_pc = 32'h0;
  logic [1:0]  m_cause = 2'd0;

  always #5 clk = ~clk;

  instr_fetch #(.TIMEOUT_CYCLES(TO_MAIN)) u_dut (
    .clk(clk), .rst(rst), .fetch_start_i(start), .pc_i(pc),
    .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata), .imem_err_i(err),
    .ir_o(ir), .ir_pc_o(ir_pc), .pc_next_o(pc_next), .pc_ld_o(pc_ld),
    .fetch_done_o(done), .fetch_fault_o(fault), .fault_cause_o(cause),
    .busy_o(busy)
  );

  // Second instance with a short timeout and a memory that never grants.
  instr_fetch #(.TIMEOUT_CYCLES(TO_SHORT)) u_to (
    .clk(clk), .rst(rst), .fetch_start_i(t_start), .pc_i(t_pc),
    .imem_req_o(t_req), .imem_addr_o(t_addr), .imem_gnt_i(1'b0),
    .imem_rvalid_i(1'b0), .imem_rdata_i(32'h0), .imem_err_i(1'b0),
    .ir_o(t_ir), .ir_pc_o(t_ir_pc), .pc_next_o(t_pc_next), .pc_ld_o(t_pc_ld),
    .fetch_done_o(t_done), .fetch_fault_o(t_fault), .fault_cause_o(t_cause),
    .busy_o(t_busy)
  );

  task automatic test_reset();
    logic [31:0] exp_next;
    exp_next = m_ir_pc + 32'd4;
    n_checks++; if (req !== 1'b0) $display("FAIL reset_req got %b exp 0", req); else n_pass++;
    n_checks++; if (addr !== 32'h0) $display("FAIL reset_addr got %h exp 0", addr); else n_pass++;
    n_checks++; if (ir !== NOP) $display("FAIL reset_ir got %h exp %h", ir, NOP); else n_pass++;
    n_checks++; if (ir_pc !== 32'h0) $display("FAIL reset_ir_pc got %h exp 0", ir_pc); else n_pass++;
    n_checks++; if (pc_next !== exp_next) $display("FAIL reset_pc_next got %h exp %h", pc_next, exp_next); else n_pass++;
    n_checks++; if ({pc_ld, done, fault, busy} !== 4'b0) $display("FAIL reset_strobes got %b exp 0000", {pc_ld, done, fault, busy}); else n_pass++;
    n_checks++; if (cause !== 2'd0) $display("FAIL reset_cause got %0d exp 0", cause); else n_pass++;
  endtask

  // Memory delays: gnt arrives in transaction cycle gd+1, rvalid rd cycles after gnt.
  task automatic run_fetch(input logic [31:0] fpc, input int gd, input int rd,
                           input bit ferr, input logic [31:0] fdata, input int bstart);
    int          resp_k, out_k;
    bit          is_done;
    logic [1:0]  exp_cause;
    logic [31:0] exp_next;
    resp_k = gd + rd + 1;
    if (fpc[1:0] != 2'b00) begin
      out_k = 0; is_done = 0; exp_cause = 2'd1;
    end else if (resp_k <= TO_MAIN) begin
      out_k = resp_k; is_done = !ferr; exp_cause = ferr ? 2'd2 : 2'd0;
    end else begin
      out_k = TO_MAIN; is_done = 0; exp_cause = 2'd3;
    end
    start = 1'b1; pc = fpc;
    gnt = 1'($urandom); rvalid = 1'($urandom); err = 1'($urandom); rdata = $urandom;
    for (int k = 1; k <= out_k + 2; k++) begin
      @(posedge clk); #1;
      start = (k == bstart); pc = $urandom;
      gnt = 1'b0; rvalid = 1'b0; err = 1'($urandom); rdata = $urandom;
      if (k <= out_k) begin
        n_checks++; if (busy !== 1'b1) $display("FAIL xfer_busy k=%0d got %b exp 1", k, busy); else n_pass++;
        n_checks++; if (req !== (k <= gd + 1)) $display("FAIL xfer_req k=%0d got %b exp %b", k, req, (k <= gd + 1)); else n_pass++;
        if (k <= gd + 1) begin
          n_checks++; if (addr !== fpc) $display("FAIL xfer_addr k=%0d got %h exp %h", k, addr, fpc); else n_pass++;
        end
        n_checks++; if ({done, fault, pc_ld} !== 3'b0) $display("FAIL xfer_strobes k=%0d got %b exp 000", k, {done, fault, pc_ld}); else n_pass++;
        n_checks++; if (cause !== 2'd0) $display("FAIL xfer_cause k=%0d got %0d exp 0", k, cause); else n_pass++;
        if (k == gd + 1) gnt = 1'b1;
        if (k == resp_k) begin rvalid = 1'b1; err = ferr; rdata = fdata; end
      end else if (k == out_k + 1) begin
        if (is_done) begin m_ir = fdata; m_ir_pc = fpc; end
        m_cause  = exp_cause;
        exp_next = m_ir_pc + 32'd4;
        n_checks++; if (done !== is_done) $display("FAIL out_done got %b exp %b", done, is_done); else n_pass++;
        n_checks++; if (pc_ld !== is_done) $display("FAIL out_pc_ld got %b exp %b", pc_ld, is_done); else n_pass++;
        n_checks++; if (fault !== !is_done) $display("FAIL out_fault got %b exp %b", fault, !is_done); else n_pass++;
        n_checks++; if (cause !== m_cause) $display("FAIL out_cause got %0d exp %0d", cause, m_cause); else n_pass++;
        n_checks++; if (ir !== m_ir) $display("FAIL out_ir got %h exp %h", ir, m_ir); else n_pass++;
        n_checks++; if (ir_pc !== m_ir_pc) $display("FAIL out_ir_pc got %h exp %h", ir_pc, m_ir_pc); else n_pass++;
        n_checks++; if (pc_next !== exp_next) $display("FAIL out_pc_next got %h exp %h", pc_next, exp_next); else n_pass++;
        n_checks++; if ({busy, req} !== 2'b10) $display("FAIL out_busy_req got %b exp 10", {busy, req}); else n_pass++;
        rvalid = 1'($urandom);
      end else begin
        n_checks++; if ({busy, req, done, fault, pc_ld} !== 5'b0) $display("FAIL idle_flags got %b exp 00000", {busy, req, done, fault, pc_ld}); else n_pass++;
        n_checks++; if (ir !== m_ir || cause !== m_cause) $display("FAIL idle_hold got ir=%h cause=%0d exp ir=%h cause=%0d", ir, cause, m_ir, m_cause); else n_pass++;
        rvalid = 1'($urandom);
      end
    end
    start = 1'b0; gnt = 1'b0; rvalid = 1'b0; err = 1'b0;
  endtask

  task automatic test_misaligned();
    run_fetch(32'h8000_0002, 0, 0, 1'b0, 32'hDEAD_BEEF, 0);
  endtask

  task automatic test_basic();
    run_fetch(32'h8000_0000, 0, 0, 1'b0, 32'h0050_0093, 0);
  endtask

  task automatic test_wait_states();
    run_fetch(32'h8000_0010, 2, 3, 1'b0, 32'h1234_5678, 0);
  endtask

  task automatic test_bus_error();
    run_fetch(32'h0000_0100, 1, 1, 1'b1, 32'hCAFE_F00D, 0);
    run_fetch(32'h0000_0104, 0, 1, 1'b0, 32'h00A0_0113, 0);
  endtask

  task automatic test_wrap_busy();
    run_fetch(32'hFFFF_FFFC, 1, 2, 1'b0, 32'h0000_006F, 2);
    n_checks++; if (pc_next !== 32'h0) $display("FAIL wrap_pc_next got %h exp 0", pc_next); else n_pass++;
  endtask

  task automatic test_timeout();
    t_start = 1'b1; t_pc = 32'h0000_0200;
    for (int k = 1; k <= TO_SHORT + 2; k++) begin
      @(posedge clk); #1;
      t_start = 1'b0;
      if (k <= TO_SHORT) begin
        n_checks++; if ({t_req, t_busy} !== 2'b11) $display("FAIL to_req k=%0d got %b exp 11", k, {t_req, t_busy}); else n_pass++;
        n_checks++; if (t_addr !== 32'h0000_0200) $display("FAIL to_addr k=%0d got %h exp 200", k, t_addr); else n_pass++;
      end else if (k == TO_SHORT + 1) begin
        n_checks++; if ({t_fault, t_req, t_done, t_pc_ld} !== 4'b1000) $display("FAIL to_fault got %b exp 1000", {t_fault, t_req, t_done, t_pc_ld}); else n_pass++;
        n_checks++; if (t_cause !== 2'd3) $display("FAIL to_cause got %0d exp 3", t_cause); else n_pass++;
        n_checks++; if (t_ir !== NOP || t_ir_pc !== 32'h0 || t_pc_next !== 32'h4) $display("FAIL to_ir got %h/%h/%h exp %h/0/4", t_ir, t_ir_pc, t_pc_next, NOP); else n_pass++;
      end else begin
        n_checks++; if ({t_busy, t_fault} !== 2'b00 || t_cause !== 2'd3) $display("FAIL to_idle got busy=%b cause=%0d exp 0/3", t_busy, t_cause); else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] rpc;
    for (int i = 0; i < 24; i++) begin
      rpc = $urandom;
      if ($urandom_range(0, 5) != 0) rpc[1:0] = 2'b00;
      run_fetch(rpc, $urandom_range(0, 4), $urandom_range(0, 4),
                ($urandom_range(0, 4) == 0), $urandom, $urandom_range(0, 3));
    end
  endtask

  task automatic test_mid_reset();
    run_fetch(32'h0000_0400, 0, 0, 1'b0, 32'h0010_0093, 0);
    start = 1'b1; pc = 32'h0000_0800;
    @(posedge clk); #1;
    start = 1'b0; gnt = 1'b1;
    @(posedge clk); #1;
    gnt = 1'b0;
    n_checks++; if ({busy, req} !== 2'b10) $display("FAIL mr_wait got %b exp 10", {busy, req}); else n_pass++;
    rst = 1'b1;
    #1;
    m_ir = NOP; m_ir_pc = 32'h0; m_cause = 2'd0;
    test_reset();
    #2 rst = 1'b0;
    rvalid = 1'b1; rdata = 32'h7777_7777; err = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_checks++; if (ir !== NOP || done !== 1'b0 || busy !== 1'b0) $display("FAIL mr_late_resp got ir=%h done=%b busy=%b exp %h/0/0", ir, done, busy, NOP); else n_pass++;
    end
    rvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; pc = 32'h0; gnt = 1'b0; rvalid = 1'b0; err = 1'b0; rdata = 32'h0;
    t_start = 1'b0; t_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    @(posedge clk); #1;
    test_misaligned();
    test_basic();
    test_wait_states();
    test_bus_error();
    test_wrap_busy();
    test_timeout();
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
